// File: rtl/multdiv_unit_if.sv
// rtl/multdiv_unit_if.sv - issue/result bundle between execute stage and multdiv_unit
interface multdiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [TAG_W-1:0] rd_in;
  logic             busy;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAG_W-1:0] rd_out;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, rd_in,
    input  busy, data_result, data_exception, data_resultRDY, rd_out
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, rd_in,
    output busy, data_result, data_exception, data_resultRDY, rd_out
  );
endinterface

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide unit; MULTDIV_BOOTH4_EN selects radix-4 Booth multiply
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

`ifdef MULTDIV_BOOTH4_EN
  localparam logic [4:0] MUL_LAST  = 5'd15;
  localparam int         MUL_SHIFT = 2;
`else
  localparam logic [4:0] MUL_LAST  = 5'd31;
  localparam int         MUL_SHIFT = 1;
`endif
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  // acc: product accumulator (mul) or partial remainder (div)
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // sh_a: shifting multiplicand (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] sh_a_q, sh_a_d;
  // sh_b: shifting multiplier (mul) or dividend/quotient shifter (div)
  logic [WIDTH:0]     sh_b_q, sh_b_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] mul_acc, mul_prod;
  logic [WIDTH:0]     div_r, div_rem;
  logic               div_ge;
  logic [WIDTH-1:0]   div_quo, div_res;

  assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_BOOTH4_EN
  logic [2*WIDTH-1:0] booth_add;

  // Radix-4 Booth: recode the next multiplier triple into 0, +-A or +-2A
  always_comb begin
    booth_add = '0;
    case (sh_b_q[2:0])
      3'b001, 3'b010: booth_add = sh_a_q;
      3'b011:         booth_add = sh_a_q << 1;
      3'b100:         booth_add = -(sh_a_q << 1);
      3'b101, 3'b110: booth_add = -sh_a_q;
      default:        booth_add = '0;
    endcase
  end

  assign mul_acc  = acc_q + booth_add;
  assign mul_prod = mul_acc;
`else
  // Radix-2 shift-add on magnitudes; sign restored on the final product
  assign mul_acc  = acc_q + (sh_b_q[0] ? sh_a_q : '0);
  assign mul_prod = neg_q ? -mul_acc : mul_acc;
`endif

  // Restoring division step: shift in the next dividend bit, subtract if it fits
  assign div_r   = {acc_q[WIDTH-1:0], sh_b_q[WIDTH-1]};
  assign div_ge  = div_r >= {1'b0, sh_a_q[WIDTH-1:0]};
  assign div_rem = div_ge ? div_r - {1'b0, sh_a_q[WIDTH-1:0]} : div_r;
  assign div_quo = {sh_b_q[WIDTH-2:0], div_ge};
  assign div_res = neg_q ? -div_quo : div_quo;

  // Next-state: start capture, one iteration per cycle, result commit on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    tag_d   = tag_q;
    rd_d    = rd_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          cnt_d = '0;
          acc_d = '0;
          tag_d = bus.rd_in;
          neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          ovf_d = 1'b0;
          dz_d  = 1'b0;
          if (bus.ctrl_MULT) begin
            state_d = MULT;
`ifdef MULTDIV_BOOTH4_EN
            sh_a_d = {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            sh_b_d = {bus.data_operandB, 1'b0};
`else
            sh_a_d = {{WIDTH{1'b0}}, mag_a};
            sh_b_d = {1'b0, mag_b};
`endif
          end else begin
            state_d = DIV;
            sh_a_d  = {{WIDTH{1'b0}}, mag_b};
            sh_b_d  = {1'b0, mag_a};
            dz_d    = (bus.data_operandB == '0);
            ovf_d   = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.data_operandB == '1);
          end
        end
      end
      MULT: begin
        acc_d  = mul_acc;
        sh_a_d = sh_a_q << MUL_SHIFT;
        sh_b_d = sh_b_q >> MUL_SHIFT;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) begin
          state_d = DONE;
          res_d   = mul_prod[WIDTH-1:0];
          exc_d   = mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}};
          rd_d    = tag_q;
        end
      end
      DIV: begin
        acc_d  = {{(WIDTH-1){1'b0}}, div_rem};
        sh_b_d = {1'b0, div_quo};
        cnt_d  = cnt_q + 5'd1;
        if (dz_q) begin
          state_d = DONE;
          res_d   = '0;
          exc_d   = 1'b1;
          rd_d    = tag_q;
        end else if (cnt_q == DIV_LAST) begin
          state_d = DONE;
          res_d   = div_res;
          exc_d   = ovf_q;
          rd_d    = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset aborting any operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      tag_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.busy           = (state_q == MULT) || (state_q == DIV);
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.rd_out         = rd_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic clock;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  multdiv_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

  multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // kind: 0 = multiply, 1 = divide, 2 = both starts high
  task automatic run_op(input string name, input int kind, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int pulse_at);
    int lat;
    logic busy_bad;
    @(negedge clock);
    bus.ctrl_MULT     = (kind != 1);
    bus.ctrl_DIV      = (kind != 0);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.rd_in         = rd;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.rd_in     = ~rd;
    check({name, "_start_busy"}, 64'(bus.busy), 64'(1));
    check({name, "_start_rdy"}, 64'(bus.data_resultRDY), 64'(0));
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.data_resultRDY && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
      if (!bus.data_resultRDY && !bus.busy) busy_bad = 1'b1;
      bus.ctrl_DIV = (lat == pulse_at);
    end
    bus.ctrl_DIV = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_held"}, 64'(busy_bad), 64'(0));
    check({name, "_done_busy"}, 64'(bus.busy), 64'(0));
    check({name, "_result"}, 64'(bus.data_result), 64'(exp_res));
    check({name, "_exception"}, 64'(bus.data_exception), 64'(exp_exc));
    check({name, "_rd_out"}, 64'(bus.rd_out), 64'(rd));
  endtask

  // Counts strobes over n cycles, also checks the held outputs do not move
  task automatic no_strobe(input string name, input int n,
                           input logic [31:0] hold_res, input logic hold_exc);
    int strobes;
    logic moved;
    strobes = 0;
    moved = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) strobes++;
      if (bus.data_result !== hold_res || bus.data_exception !== hold_exc) moved = 1'b1;
    end
    check({name, "_strobes"}, 64'(strobes), 64'(0));
    check({name, "_hold"}, 64'(moved), 64'(0));
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    reset = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.rd_in         = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("rst_result", 64'(bus.data_result), 64'(0));
    check("rst_exc", 64'(bus.data_exception), 64'(0));
    check("rst_rd", 64'(bus.rd_out), 64'(0));

    run_op("mul_7x8", 0, 32'd7, 32'd8, 5'd3, 32'd56, 1'b0, MUL_LAT, -1);
    @(posedge clock);
    #1;
    check("mul_7x8_rdy_drop", 64'(bus.data_resultRDY), 64'(0));
    check("mul_7x8_held", 64'(bus.data_result), 64'(56));

    run_op("div_m6_4", 1, 32'hFFFFFFFA, 32'd4, 5'd4, 32'hFFFFFFFF, 1'b0, DIV_LAT, -1);
    run_op("div_100_m7", 1, 32'd100, 32'hFFFFFFF9, 5'd5, 32'hFFFFFFF2, 1'b0, DIV_LAT, -1);
    run_op("div_7_0", 1, 32'd7, 32'd0, 5'd6, 32'd0, 1'b1, 1, -1);
    run_op("mul_ovf", 0, 32'h00010000, 32'h00010000, 5'd7, 32'd0, 1'b1, MUL_LAT, -1);
    run_op("mul_min_1", 0, 32'h80000000, 32'd1, 5'd8, 32'h80000000, 1'b0, MUL_LAT, -1);
    run_op("div_min_m1", 1, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 1'b1, DIV_LAT, -1);
    run_op("mul_m7_m9", 0, 32'hFFFFFFF9, 32'hFFFFFFF7, 5'd10, 32'd63, 1'b0, MUL_LAT, -1);
    run_op("mul_zero", 0, 32'd0, 32'd12345, 5'd11, 32'd0, 1'b0, MUL_LAT, -1);
    run_op("div_zero_num", 1, 32'd0, 32'd5, 5'd12, 32'd0, 1'b0, DIV_LAT, -1);
    run_op("both_start", 2, 32'hFFFFFFFD, 32'd4, 5'd13, 32'hFFFFFFF4, 1'b0, MUL_LAT, -1);

    run_op("mul_div_pulse", 0, 32'd7, 32'd8, 5'd14, 32'd56, 1'b0, MUL_LAT, 9);
    no_strobe("mul_div_pulse_after", 40, 32'd56, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd9;
    bus.rd_in         = 5'd15;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("abort_result", 64'(bus.data_result), 64'(0));
    check("abort_exc", 64'(bus.data_exception), 64'(0));
    check("abort_rd", 64'(bus.rd_out), 64'(0));
    no_strobe("abort_after", 40, 32'd0, 1'b0);
    run_op("mul_3_m5", 0, 32'd3, 32'hFFFFFFFB, 5'd16, 32'hFFFFFFF1, 1'b0, MUL_LAT, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide unit alongside the execute stage.
- Captures operands and the destination register tag when execute issues a mul/div.
- Asserts a stall to the hazard control while iterating.
- Presents the result, exception flag and tag for one cycle so the X/M latch can consume them.

Parameters:
- WIDTH, 32, operand and result width.
- TAG_W, 5, destination register tag width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- ctrl_MULT  in  1  start pulse for multiply; sampled when ready to accept.
- ctrl_DIV  in  1  start pulse for divide; sampled when ready to accept.
- data_operandA  in  WIDTH  multiplicand / dividend, signed.
- data_operandB  in  WIDTH  multiplier / divisor, signed.
- rd_in  in  TAG_W  destination register of the issuing instruction.
- busy  out  1  operation in flight; the hazard unit stalls F/D/X while it is high.
- data_result  out  WIDTH  product (low word) or quotient.
- data_exception  out  1  overflow or divide-by-zero.
- data_resultRDY  out  1  one-cycle valid strobe for result, exception and tag.
- rd_out  out  TAG_W  captured destination tag.

Behaviour:
- States: IDLE, MULT, DIV, DONE.
- Reset: state=IDLE, busy=0, data_resultRDY=0, data_result=0, data_exception=0, rd_out=0, iteration counter=0.
- Start acceptance:
  - Starts are accepted only in IDLE or DONE.
  - In MULT or DIV, ctrl_MULT/ctrl_DIV are ignored.
  - If both are high in the same cycle, MULT wins and DIV is ignored.
- Capture: on the accepting edge N, latch operands and rd_in (to rd_out), clear the counter, enter MULT or DIV, busy=1 from edge N.
- Iteration: one iteration per edge, 32 iterations. At edge N+32 enter DONE.
- DONE cycle: busy=0, data_resultRDY=1 for exactly one cycle. Edge N+33 returns to IDLE unless a new start is accepted.
- Back-to-back: a start accepted in DONE moves directly to MULT/DIV; data_resultRDY still drops after one cycle.
- Output hold: data_result, data_exception and rd_out hold their value after DONE until the next DONE or reset.
- Multiply:
  - Signed 32x32 shift-add on magnitudes; sign applied at the end.
  - data_result = low 32 bits of the 64-bit product.
  - data_exception=1 if the 64-bit product is not the sign extension of bit 31.
- Divide:
  - Signed restoring division on magnitudes.
  - Quotient truncates toward zero; quotient sign = signA XOR signB.
  - Remainder is discarded.
- Divide by zero:
  - Detected at capture; enter DONE at edge N+1 (latency 1).
  - data_result=0, data_exception=1.
- Divide 0x80000000 / -1: data_result=0x80000000, data_exception=1, full 32-iteration latency.
- Zero operand: normal latency, result 0, no exception.
- Reset mid-operation: abort immediately to reset values. No data_resultRDY is produced for the aborted operation.

Optional Feature:
- Macro: MULTDIV_BOOTH4_EN.
- Defined:
  - Multiply uses radix-4 Booth recoding, 16 iterations.
  - DONE at edge N+16; exception rule and result are identical.
  - Divide is unchanged.
- Undefined: radix-2 shift-add, 32 iterations as above.

Test Plan:
- Multiply 7 x 8, start at edge N, rd_in=3 -> busy=1 edges N..N+31; at N+32: data_resultRDY=1 for one cycle, data_result=56, data_exception=0, rd_out=3. With MULTDIV_BOOTH4_EN the strobe comes at N+16.
- Divide -6 / 4 -> data_result=0xFFFFFFFF (-1), exception=0, strobe at N+32. Divide 100 / -7 -> -14.
- Divide 7 / 0 -> strobe at N+1, data_result=0, data_exception=1.
- Multiply 0x00010000 x 0x00010000 -> data_result=0, exception=1. Multiply 0x80000000 x 1 -> 0x80000000, exception=0. Divide 0x80000000 / -1 -> 0x80000000, exception=1.
- ctrl_DIV pulsed mid-multiply at N+10 -> ignored; only one strobe at N+32 carrying the product. ctrl_MULT and ctrl_DIV together -> multiply performed.
- Reset asserted at N+12 of a multiply -> next edge: busy=0, outputs zero, no strobe within 40 cycles. A new multiply 3 x -5 then yields -15 at its own N+32.
